// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD target model: opcode masks,
// DDRAM geometry, FSM/command enums and address-counter stepping.
package lcd_pkg;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;
  localparam logic [7:0] CMD_ENTRY = 8'h04;
  localparam logic [7:0] CMD_DISP  = 8'h08;
  localparam logic [7:0] CMD_SHIFT = 8'h10;
  localparam logic [7:0] CMD_FUNC  = 8'h20;
  localparam logic [7:0] CMD_CGRAM = 8'h40;
  localparam logic [7:0] CMD_DDRAM = 8'h80;

  localparam logic [6:0] LINE0_BASE  = 7'h00;
  localparam logic [6:0] LINE1_BASE  = 7'h40;
  localparam logic [6:0] LINE_LAST   = 7'h27;
  localparam int unsigned COLS       = 16;
  localparam int unsigned DDRAM_DEPTH = 2 * COLS;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam int unsigned CNT_W      = 16;

  typedef enum logic [1:0] {StIdle, StExec, StClearing, StBusyWait} state_e;

  typedef enum logic [3:0] {
    CmdNop, CmdClear, CmdHome, CmdEntry, CmdDisp, CmdShift, CmdFunc, CmdCgram, CmdDdram
  } cmd_e;

  // The highest set bit selects the instruction.
  function automatic cmd_e cmd_decode(input logic [7:0] d);
    cmd_e cmd;
    if ((d & CMD_DDRAM) != 8'h00)      cmd = CmdDdram;
    else if ((d & CMD_CGRAM) != 8'h00) cmd = CmdCgram;
    else if ((d & CMD_FUNC) != 8'h00)  cmd = CmdFunc;
    else if ((d & CMD_SHIFT) != 8'h00) cmd = CmdShift;
    else if ((d & CMD_DISP) != 8'h00)  cmd = CmdDisp;
    else if ((d & CMD_ENTRY) != 8'h00) cmd = CmdEntry;
    else if ((d & CMD_HOME) != 8'h00)  cmd = CmdHome;
    else if ((d & CMD_CLEAR) != 8'h00) cmd = CmdClear;
    else                               cmd = CmdNop;
    return cmd;
  endfunction

  // Two 40-byte line windows chained end to end in both directions.
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    logic [6:0] nxt;
    if (inc) begin
      if (ac == LINE0_BASE + LINE_LAST)      nxt = LINE1_BASE;
      else if (ac == LINE1_BASE + LINE_LAST) nxt = LINE0_BASE;
      else                                   nxt = ac + 7'd1;
    end else begin
      if (ac == LINE1_BASE)      nxt = LINE0_BASE + LINE_LAST;
      else if (ac == LINE0_BASE) nxt = LINE1_BASE + LINE_LAST;
      else                       nxt = ac - 7'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/lcd_bus_sync.sv
// Two-flop synchronizer for the asynchronous LCD bus; flags the synchronized
// falling edge of e and holds rs/rw/data as sampled while e was high.
module lcd_bus_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic       pin_e,
  input  logic       pin_rs,
  input  logic       pin_rw,
  input  logic [7:0] pin_data,
  output logic       e_fall,
  output logic       e_high,
  output logic       rs,
  output logic       rw,
  output logic [7:0] data
);

  logic [10:0] meta_q;
  logic [10:0] sync_q;
  logic [9:0]  hold_q;
  logic        e_prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q   <= '0;
      sync_q   <= '0;
      hold_q   <= '0;
      e_prev_q <= 1'b0;
    end else begin
      meta_q   <= {pin_e, pin_rs, pin_rw, pin_data};
      sync_q   <= meta_q;
      e_prev_q <= sync_q[10];
      if (sync_q[10]) hold_q <= sync_q[9:0];
    end
  end

  assign e_high = sync_q[10];
  assign e_fall = e_prev_q & ~sync_q[10];
  // After e drops the pins may already be changing; present the last e-high sample.
  assign {rs, rw, data} = e_high ? sync_q[9:0] : hold_q;

endmodule

// File: rtl/lcd_responder.sv
// Target-side model of a 2x16 character LCD: decodes bus accesses, executes the
// command set against a 32-byte DDRAM and exposes a registered scanner read port.
module lcd_responder
  import lcd_pkg::*;
#(
  parameter int unsigned BUSY_CYCLES = 4,
  parameter int unsigned HOME_CYCLES = 16,
  parameter int unsigned CLR_CYCLES  = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data_in,
  output logic [7:0] lcd_data_out,
  output logic       lcd_data_oe,
  input  logic       rd_line,
  input  logic [3:0] rd_col,
  output logic [7:0] rd_char,
  output logic [6:0] addr_cnt,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       inc_dec,
  output logic       two_line,
  output logic       busy,
  output logic       overrun
);

  logic       bus_e_fall, bus_e_high, bus_rs, bus_rw;
  logic [7:0] bus_data;

  lcd_bus_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .pin_e    (lcd_e),
    .pin_rs   (lcd_rs),
    .pin_rw   (lcd_rw),
    .pin_data (lcd_data_in),
    .e_fall   (bus_e_fall),
    .e_high   (bus_e_high),
    .rs       (bus_rs),
    .rw       (bus_rw),
    .data     (bus_data)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       clr_idx_q, clr_idx_d;
  logic [6:0]       ac_q, ac_d;
  logic             disp_q, disp_d, cursor_q, cursor_d, blink_q, blink_d;
  logic             inc_dec_q, inc_dec_d, two_line_q, two_line_d;
  logic             overrun_q, overrun_d;
  logic [7:0]       ddram_q [DDRAM_DEPTH];
  logic [7:0]       rd_char_q;

  logic       mem_we;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       ac_mapped;
  logic [4:0] ac_idx;
  logic [7:0] ac_char;
  logic       wr_acc, rd_acc;

  assign busy      = (state_q != StIdle);
  assign ac_mapped = (ac_q[5:4] == 2'b00);
  assign ac_idx    = {ac_q[6], ac_q[3:0]};
  assign ac_char   = ac_mapped ? ddram_q[ac_idx] : ASCII_SPACE;
  assign wr_acc    = bus_e_fall & ~bus_rw;
  assign rd_acc    = bus_e_fall & bus_rw;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_idx_d  = clr_idx_q;
    ac_d       = ac_q;
    disp_d     = disp_q;
    cursor_d   = cursor_q;
    blink_d    = blink_q;
    inc_dec_d  = inc_dec_q;
    two_line_d = two_line_q;
    overrun_d  = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = ac_idx;
    mem_wdata  = bus_data;

    // cnt_q holds the remaining busy cycles minus one; busy ends when it hits zero.
    if (state_q != StIdle) cnt_d = cnt_q - 1'b1;

    unique case (state_q)
      StIdle:     ;
      StExec:     state_d = StBusyWait;
      StClearing: begin
        mem_we    = 1'b1;
        mem_addr  = clr_idx_q;
        mem_wdata = ASCII_SPACE;
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == 5'(DDRAM_DEPTH - 1)) state_d = StBusyWait;
      end
      StBusyWait: ;
    endcase

    if (state_q != StIdle && cnt_q == '0) state_d = StIdle;

    if (wr_acc) begin
      if (busy) begin
        overrun_d = 1'b1;
      end else if (bus_rs) begin
        mem_we  = ac_mapped;
        ac_d    = ac_step(ac_q, inc_dec_q);
        state_d = StExec;
        cnt_d   = CNT_W'(BUSY_CYCLES - 1);
      end else begin
        state_d = StExec;
        cnt_d   = CNT_W'(BUSY_CYCLES - 1);
        unique case (cmd_decode(bus_data))
          CmdDdram: ac_d = bus_data[6:0];
          CmdCgram: ;
          CmdFunc:  two_line_d = bus_data[3];
          CmdShift: if (!bus_data[3]) ac_d = ac_step(ac_q, bus_data[2]);
          CmdDisp:  {disp_d, cursor_d, blink_d} = bus_data[2:0];
          CmdEntry: inc_dec_d = bus_data[1];
          CmdHome: begin
            ac_d  = LINE0_BASE;
            cnt_d = CNT_W'(HOME_CYCLES - 1);
          end
          CmdClear: begin
            ac_d      = LINE0_BASE;
            inc_dec_d = 1'b1;
            clr_idx_d = '0;
            state_d   = StClearing;
            cnt_d     = CNT_W'(CLR_CYCLES - 1);
          end
          CmdNop: state_d = StIdle;
        endcase
      end
    end else if (rd_acc && bus_rs) begin
      ac_d = ac_step(ac_q, inc_dec_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      clr_idx_q  <= '0;
      ac_q       <= LINE0_BASE;
      disp_q     <= 1'b0;
      cursor_q   <= 1'b0;
      blink_q    <= 1'b0;
      inc_dec_q  <= 1'b1;
      two_line_q <= 1'b0;
      overrun_q  <= 1'b0;
      rd_char_q  <= ASCII_SPACE;
      for (int i = 0; i < DDRAM_DEPTH; i++) ddram_q[i] <= ASCII_SPACE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_idx_q  <= clr_idx_d;
      ac_q       <= ac_d;
      disp_q     <= disp_d;
      cursor_q   <= cursor_d;
      blink_q    <= blink_d;
      inc_dec_q  <= inc_dec_d;
      two_line_q <= two_line_d;
      overrun_q  <= overrun_d;
      rd_char_q  <= ddram_q[{rd_line, rd_col}];
      if (mem_we) ddram_q[mem_addr] <= mem_wdata;
    end
  end

  assign lcd_data_oe  = bus_e_high & bus_rw;
  assign lcd_data_out = lcd_data_oe ? (bus_rs ? ac_char : {busy, ac_q}) : 8'h00;
  assign rd_char      = rd_char_q;
  assign addr_cnt     = ac_q;
  assign disp_on      = disp_q;
  assign cursor_on    = cursor_q;
  assign blink_on     = blink_q;
  assign inc_dec      = inc_dec_q;
  assign two_line     = two_line_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_lcd_responder.sv
// Directed self-checking bench for lcd_responder: bus writes/reads, command set,
// clear timing, overrun, address wrap and reset during clear.
module tb_lcd_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic       lcd_e, lcd_rs, lcd_rw;
  logic [7:0] lcd_data_in, lcd_data_out, rd_char;
  logic       lcd_data_oe, rd_line;
  logic [3:0] rd_col;
  logic [6:0] addr_cnt;
  logic       disp_on, cursor_on, blink_on, inc_dec, two_line, busy, overrun;

  int n_checks = 0;
  int n_pass   = 0;

  lcd_responder dut (
    .clk          (clk),
    .reset        (reset),
    .lcd_e        (lcd_e),
    .lcd_rs       (lcd_rs),
    .lcd_rw       (lcd_rw),
    .lcd_data_in  (lcd_data_in),
    .lcd_data_out (lcd_data_out),
    .lcd_data_oe  (lcd_data_oe),
    .rd_line      (rd_line),
    .rd_col       (rd_col),
    .rd_char      (rd_char),
    .addr_cnt     (addr_cnt),
    .disp_on      (disp_on),
    .cursor_on    (cursor_on),
    .blink_on     (blink_on),
    .inc_dec      (inc_dec),
    .two_line     (two_line),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic pulse(input logic rs, input logic rw, input logic [7:0] d);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = rw; lcd_data_in = d; lcd_e = 1'b1;
    repeat (4) @(negedge clk);
    lcd_e = 1'b0;
  endtask

  // Access executes on the third rising edge after the pin falls.
  task automatic wait_exec();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    if (busy !== 1'b0) begin
      n_checks++;
      $display("FAIL wait_idle: busy=%b still set after 100 cycles", busy);
    end
  endtask

  task automatic wr(input logic rs, input logic [7:0] d);
    pulse(rs, 1'b0, d);
    wait_exec();
    wait_idle();
  endtask

  task automatic rd(input logic line, input logic [3:0] col, output logic [7:0] v);
    @(negedge clk);
    rd_line = line; rd_col = col;
    @(posedge clk); #1;
    v = rd_char;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; lcd_e = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data_in = 8'h00;
    rd_line = 1'b0; rd_col = 4'd0;
    repeat (3) @(posedge clk); #1;
    n_checks++; if (addr_cnt !== 7'h00) $display("FAIL rst_ac: got %h want 00", addr_cnt); else n_pass++;
    n_checks++; if ({disp_on, cursor_on, blink_on} !== 3'b000)
      $display("FAIL rst_disp: got %b want 000", {disp_on, cursor_on, blink_on}); else n_pass++;
    n_checks++; if (inc_dec !== 1'b1) $display("FAIL rst_incdec: got %b want 1", inc_dec); else n_pass++;
    n_checks++; if (two_line !== 1'b0) $display("FAIL rst_twoline: got %b want 0", two_line); else n_pass++;
    n_checks++; if ({busy, overrun} !== 2'b00)
      $display("FAIL rst_busy: got %b want 00", {busy, overrun}); else n_pass++;
    n_checks++; if ({lcd_data_oe, lcd_data_out} !== 9'h000)
      $display("FAIL rst_bus: got %h want 000", {lcd_data_oe, lcd_data_out}); else n_pass++;
    n_checks++; if (rd_char !== 8'h20) $display("FAIL rst_rdchar: got %h want 20", rd_char); else n_pass++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_init();
    pulse(1'b0, 1'b0, 8'h3C);
    repeat (2) @(posedge clk); #1;
    n_checks++; if (two_line !== 1'b0) $display("FAIL init_early: got %b want 0", two_line); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if ({two_line, busy} !== 2'b11)
      $display("FAIL init_func: got %b want 11", {two_line, busy}); else n_pass++;
    repeat (3) @(posedge clk); #1;
    n_checks++; if (busy !== 1'b1) $display("FAIL init_busy_hold: got %b want 1", busy); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL init_busy_fall: got %b want 0", busy); else n_pass++;
    wr(1'b0, 8'h0C);
    wr(1'b0, 8'h06);
    n_checks++; if ({disp_on, cursor_on, blink_on} !== 3'b100)
      $display("FAIL init_disp: got %b want 100", {disp_on, cursor_on, blink_on}); else n_pass++;
    n_checks++; if ({inc_dec, addr_cnt} !== {1'b1, 7'h00})
      $display("FAIL init_entry: got %h want 80", {inc_dec, addr_cnt}); else n_pass++;
  endtask

  task automatic test_data_write();
    logic [7:0] v;
    wr(1'b0, 8'h80);
    wr(1'b1, 8'h32);
    wr(1'b1, 8'h30);
    n_checks++; if (addr_cnt !== 7'h02) $display("FAIL dw_ac: got %h want 02", addr_cnt); else n_pass++;
    rd(1'b0, 4'd1, v);
    n_checks++; if (v !== 8'h30) $display("FAIL dw_cell1: got %h want 30", v); else n_pass++;
    rd(1'b0, 4'd0, v);
    n_checks++; if (v !== 8'h32) $display("FAIL dw_cell0: got %h want 32", v); else n_pass++;
  endtask

  task automatic test_commands();
    int n;
    wr(1'b0, 8'h14);
    n_checks++; if (addr_cnt !== 7'h03) $display("FAIL shift_r: got %h want 03", addr_cnt); else n_pass++;
    wr(1'b0, 8'h10);
    n_checks++; if (addr_cnt !== 7'h02) $display("FAIL shift_l: got %h want 02", addr_cnt); else n_pass++;
    wr(1'b0, 8'h1C);
    n_checks++; if (addr_cnt !== 7'h02) $display("FAIL shift_s1: got %h want 02", addr_cnt); else n_pass++;
    wr(1'b0, 8'h0F);
    n_checks++; if ({disp_on, cursor_on, blink_on} !== 3'b111)
      $display("FAIL disp_all: got %b want 111", {disp_on, cursor_on, blink_on}); else n_pass++;
    wr(1'b0, 8'h0C);
    pulse(1'b0, 1'b0, 8'h40);
    wait_exec();
    n_checks++; if ({busy, addr_cnt} !== {1'b1, 7'h02})
      $display("FAIL cgram: got %h want 82", {busy, addr_cnt}); else n_pass++;
    wait_idle();
    pulse(1'b0, 1'b0, 8'h00);
    wait_exec();
    n_checks++; if (busy !== 1'b0) $display("FAIL nop_busy: got %b want 0", busy); else n_pass++;
    pulse(1'b0, 1'b0, 8'h02);
    wait_exec();
    n_checks++; if (addr_cnt !== 7'h00) $display("FAIL home_ac: got %h want 00", addr_cnt); else n_pass++;
    count_busy(n);
    n_checks++; if (n != 16) $display("FAIL home_busy: got %0d cycles want 16", n); else n_pass++;
  endtask

  task automatic test_read();
    @(negedge clk);
    lcd_rs = 1'b1; lcd_rw = 1'b1; lcd_e = 1'b1;
    repeat (3) @(posedge clk); #1;
    n_checks++; if ({lcd_data_oe, lcd_data_out} !== 9'h132)
      $display("FAIL rd_data: got %h want 132", {lcd_data_oe, lcd_data_out}); else n_pass++;
    @(negedge clk);
    lcd_e = 1'b0;
    wait_exec();
    n_checks++; if (addr_cnt !== 7'h01) $display("FAIL rd_adv: got %h want 01", addr_cnt); else n_pass++;
    @(negedge clk);
    lcd_rs = 1'b0; lcd_e = 1'b1;
    repeat (3) @(posedge clk); #1;
    n_checks++; if ({lcd_data_oe, lcd_data_out} !== 9'h101)
      $display("FAIL rd_bf: got %h want 101", {lcd_data_oe, lcd_data_out}); else n_pass++;
    @(negedge clk);
    lcd_e = 1'b0;
    wait_exec();
    n_checks++; if ({lcd_data_oe, addr_cnt} !== 8'h01)
      $display("FAIL rd_bf_noadv: got %h want 01", {lcd_data_oe, addr_cnt}); else n_pass++;
  endtask

  task automatic test_clear();
    logic [7:0] v;
    int n;
    wr(1'b0, 8'h80);
    for (int i = 0; i < 16; i++) wr(1'b1, 8'h41 + 8'(i));
    n_checks++; if (addr_cnt !== 7'h10) $display("FAIL fill_ac: got %h want 10", addr_cnt); else n_pass++;
    rd(1'b0, 4'd15, v);
    n_checks++; if (v !== 8'h50) $display("FAIL fill_cell15: got %h want 50", v); else n_pass++;
    wr(1'b0, 8'h04);
    pulse(1'b0, 1'b0, 8'h01);
    wait_exec();
    n_checks++; if ({busy, inc_dec, addr_cnt} !== 9'h180)
      $display("FAIL clr_start: got %h want 180", {busy, inc_dec, addr_cnt}); else n_pass++;
    count_busy(n);
    n_checks++; if (n != 40) $display("FAIL clr_busy: got %0d cycles want 40", n); else n_pass++;
    for (int i = 0; i < 32; i++) begin
      rd(i[4], i[3:0], v);
      n_checks++; if (v !== 8'h20) $display("FAIL clr_cell%0d: got %h want 20", i, v); else n_pass++;
    end
  endtask

  task automatic test_wrap();
    logic [7:0] v;
    wr(1'b0, 8'hA7);
    wr(1'b1, 8'h55);
    n_checks++; if (addr_cnt !== 7'h40) $display("FAIL wrap_27: got %h want 40", addr_cnt); else n_pass++;
    wr(1'b0, 8'h04);
    wr(1'b0, 8'h80);
    wr(1'b1, 8'h58);
    n_checks++; if (addr_cnt !== 7'h67) $display("FAIL wrap_00: got %h want 67", addr_cnt); else n_pass++;
    rd(1'b0, 4'd0, v);
    n_checks++; if (v !== 8'h58) $display("FAIL wrap_cell0: got %h want 58", v); else n_pass++;
    wr(1'b0, 8'hC0);
    wr(1'b1, 8'h59);
    n_checks++; if (addr_cnt !== 7'h27) $display("FAIL wrap_40: got %h want 27", addr_cnt); else n_pass++;
    rd(1'b1, 4'd0, v);
    n_checks++; if (v !== 8'h59) $display("FAIL wrap_cell40: got %h want 59", v); else n_pass++;
    wr(1'b0, 8'h06);
  endtask

  task automatic test_overrun();
    logic [7:0] v;
    pulse(1'b0, 1'b0, 8'h01);
    wait_exec();
    pulse(1'b1, 1'b0, 8'h41);
    wait_exec();
    n_checks++; if (overrun !== 1'b1) $display("FAIL ovr_pulse: got %b want 1", overrun); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (overrun !== 1'b0) $display("FAIL ovr_single: got %b want 0", overrun); else n_pass++;
    @(negedge clk);
    lcd_rs = 1'b0; lcd_rw = 1'b1; lcd_e = 1'b1;
    repeat (3) @(posedge clk); #1;
    n_checks++; if ({lcd_data_oe, lcd_data_out} !== 9'h180)
      $display("FAIL ovr_bf: got %h want 180", {lcd_data_oe, lcd_data_out}); else n_pass++;
    @(negedge clk);
    lcd_e = 1'b0;
    wait_idle();
    n_checks++; if (addr_cnt !== 7'h00) $display("FAIL ovr_ac: got %h want 00", addr_cnt); else n_pass++;
    rd(1'b0, 4'd0, v);
    n_checks++; if (v !== 8'h20) $display("FAIL ovr_cell0: got %h want 20", v); else n_pass++;
  endtask

  task automatic test_reset_mid_clear();
    logic [7:0] v;
    wr(1'b0, 8'h8A);
    wr(1'b1, 8'h5A);
    rd(1'b0, 4'd10, v);
    n_checks++; if (v !== 8'h5A) $display("FAIL rmc_pre: got %h want 5a", v); else n_pass++;
    pulse(1'b0, 1'b0, 8'h01);
    wait_exec();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++; if ({busy, inc_dec, addr_cnt} !== 9'h080)
      $display("FAIL rmc_state: got %h want 080", {busy, inc_dec, addr_cnt}); else n_pass++;
    n_checks++; if ({two_line, disp_on, rd_char} !== 10'h020)
      $display("FAIL rmc_mode: got %h want 020", {two_line, disp_on, rd_char}); else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    rd(1'b0, 4'd10, v);
    n_checks++; if (v !== 8'h20) $display("FAIL rmc_cell10: got %h want 20", v); else n_pass++;
    repeat (4) @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL rmc_idle: got %b want 0", busy); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_init();
    test_data_write();
    test_commands();
    test_read();
    test_clear();
    test_wrap();
    test_overrun();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
